// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, defaults, FSM encoding.
package if_stage_pkg;

    localparam int unsigned INSTR_W = 32;

    // sll $0,$0,0 doubles as the pipeline bubble
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = '0;
    localparam logic [INSTR_W-1:0] RESET_PC_DEF  = '0;

    typedef enum logic [1:0] {
        StFetch = 2'd0,  // request open at pc
        StDrop  = 2'd1,  // request open at a stale address; its data is discarded
        StHold  = 2'd2   // fetched word parked in the skid buffer while stalled
    } fetch_state_e;

    // Sequential successor address; wraps modulo 2^32
    function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
        return pc + INSTR_W'(4);
    endfunction

    // Instruction fetches are always word aligned
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & ~INSTR_W'(3);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Request/acknowledge instruction-memory port between the fetch stage and memory.
interface if_stage_if;
    import if_stage_pkg::*;

    logic               req;
    logic [INSTR_W-1:0] addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/if_fetch_buf.sv
// Single-entry skid buffer holding one fetched instruction and its pc+4 while stalled.
module if_fetch_buf
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               drain,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [INSTR_W-1:0] load_pc_plus4,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic               full
);

    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] pc_plus4_q;
    logic               full_q;

    // Entry storage; clear beats load beats drain
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q    <= '0;
            pc_plus4_q <= '0;
            full_q     <= 1'b0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (load) begin
            instr_q    <= load_instr;
            pc_plus4_q <= load_pc_plus4;
            full_q     <= 1'b1;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign full     = full_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the pc, drives the imem port and feeds IF/ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    if_stage_if.master         imem,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [INSTR_W-1:0] pc_out,
    output logic               valid_out
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_out_q, pc_out_d;
    logic               valid_q, valid_d;

    logic [INSTR_W-1:0] pc_inc;
    logic [INSTR_W-1:0] redirect_target;
    logic               buf_load, buf_clear, buf_drain;
    logic [INSTR_W-1:0] buf_instr, buf_pc_plus4;
    logic               buf_full;

    assign pc_inc          = pc_plus4(pc_q);
    assign redirect_target = word_align(redirect_pc);

    if_fetch_buf u_fetch_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (buf_load),
        .clear         (buf_clear),
        .drain         (buf_drain),
        .load_instr    (imem.rdata),
        .load_pc_plus4 (pc_inc),
        .instr         (buf_instr),
        .pc_plus4      (buf_pc_plus4),
        .full          (buf_full)
    );

    // Next-state, next-pc and IF/ID output decisions; redirect outranks stall outranks ack
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        buf_drain = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (redirect_valid) begin
                    pc_d     = redirect_target;
                    instr_d  = NOP_INSTR;
                    pc_out_d = '0;
                    valid_d  = 1'b0;
                    // An unanswered request stays open; its data must be swallowed
                    if (!imem.ack) begin
                        state_d = StDrop;
                    end
                end else if (stall) begin
                    if (imem.ack) begin
                        buf_load = 1'b1;
                        state_d  = StHold;
                    end
                end else if (imem.ack) begin
                    instr_d  = imem.rdata;
                    pc_out_d = pc_inc;
                    valid_d  = 1'b1;
                    pc_d     = pc_inc;
                end else begin
                    instr_d  = NOP_INSTR;
                    pc_out_d = '0;
                    valid_d  = 1'b0;
                end
            end
            StDrop: begin
                instr_d  = NOP_INSTR;
                pc_out_d = '0;
                valid_d  = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem.ack) begin
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_target;
                    instr_d   = NOP_INSTR;
                    pc_out_d  = '0;
                    valid_d   = 1'b0;
                    state_d   = StFetch;
                end else if (!stall) begin
                    buf_drain = 1'b1;
                    instr_d   = buf_instr;
                    pc_out_d  = buf_pc_plus4;
                    valid_d   = buf_full;
                    pc_d      = pc_inc;
                    state_d   = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Entering DROP freezes the outstanding address; otherwise the request follows pc
        if (state_d == StDrop) begin
            req_addr_d = (state_q == StDrop) ? req_addr_q : pc_q;
        end else begin
            req_addr_d = pc_d;
        end
    end

    // State, pc and IF/ID output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

    assign imem.req        = (state_q != StHold);
    assign imem.addr       = req_addr_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_out_q;
    assign valid_out       = valid_q;

    // Memory may only answer while a request is open
    ack_without_req: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == StHold && imem.ack));

endmodule
